// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-side arbiter and the FIFO wrapper.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int DEF_N_REQ     = 4;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_MAX_BURST = 4;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: scans from rr_last+1 upward (mod N_REQ),
// optionally skipping one index, and returns the first requesting index.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_last,
    input  logic             excl_en,
    input  logic [IDX_W-1:0] excl_idx,
    output logic [IDX_W-1:0] winner,
    output logic             valid
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        cand   = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = IDX_W'((int'(rr_last) + i) % N_REQ);
            if (!valid && req[cand] && !(excl_en && (cand == excl_idx))) begin
                valid  = 1'b1;
                winner = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port among N_REQ producers,
// with bounded bursts per grant and stalling on FIFO full.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = DEF_N_REQ,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int IDX_W     = clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic                    fifo_full,
    output logic [N_REQ-1:0]        grant,
    output logic [N_REQ-1:0]        ack,
    output logic                    fifo_wr_en,
    output logic [DATA_W-1:0]       fifo_din,
    output logic [IDX_W-1:0]        owner,
    output logic                    busy
);

    arb_state_t       state, state_nxt;
    logic [IDX_W-1:0] owner_nxt;
    logic [IDX_W-1:0] rr_last, rr_last_nxt;
    logic [3:0]       beat_cnt, beat_nxt;
    logic [N_REQ-1:0] grant_nxt;
    logic             busy_nxt;
    logic             regrant_gap, regrant_gap_nxt;

    logic             in_grant;
    logic             owner_req;
    logic             accept;
    logic             last_beat;
    logic             release_now;
    logic [IDX_W-1:0] pick_last;
    logic [IDX_W-1:0] pick_winner;
    logic             pick_valid;
    logic [DATA_W-1:0] words [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_words
        assign words[g] = req_data[g*DATA_W +: DATA_W];
    end

    assign in_grant  = (state == GRANT);
    assign owner_req = req[owner];
    // A regranted sole owner sits out one cycle so burst boundaries stay visible.
    assign accept      = in_grant & owner_req & ~fifo_full & ~rst & ~regrant_gap;
    assign last_beat   = accept & (beat_cnt == 4'(MAX_BURST - 1));
    assign release_now = in_grant & (~owner_req | last_beat);

    // On release the scan starts just past the owner, which is excluded.
    assign pick_last = in_grant ? owner : rr_last;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req      (req),
        .rr_last  (pick_last),
        .excl_en  (in_grant),
        .excl_idx (owner),
        .winner   (pick_winner),
        .valid    (pick_valid)
    );

    assign fifo_wr_en = accept;
    assign ack        = accept ? (N_REQ'(1) << owner) : '0;
    assign fifo_din   = busy ? words[owner] : '0;

    always_comb begin
        state_nxt       = state;
        owner_nxt       = owner;
        rr_last_nxt     = rr_last;
        beat_nxt        = beat_cnt;
        grant_nxt       = grant;
        busy_nxt        = busy;
        regrant_gap_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_nxt = GRANT;
                    owner_nxt = pick_winner;
                    grant_nxt = N_REQ'(1) << pick_winner;
                    busy_nxt  = 1'b1;
                    beat_nxt  = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    rr_last_nxt = owner;
                    if (pick_valid) begin
                        owner_nxt = pick_winner;
                        grant_nxt = N_REQ'(1) << pick_winner;
                        beat_nxt  = '0;
                    end else if (owner_req && last_beat) begin
                        beat_nxt        = '0;
                        regrant_gap_nxt = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        grant_nxt = '0;
                        busy_nxt  = 1'b0;
                        beat_nxt  = '0;
                    end
                end else if (accept) begin
                    beat_nxt = beat_cnt + 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= '0;
            busy        <= 1'b0;
            owner       <= '0;
            beat_cnt    <= '0;
            rr_last     <= IDX_W'(N_REQ - 1);
            regrant_gap <= 1'b0;
        end else begin
            state       <= state_nxt;
            grant       <= grant_nxt;
            busy        <= busy_nxt;
            owner       <= owner_nxt;
            beat_cnt    <= beat_nxt;
            rr_last     <= rr_last_nxt;
            regrant_gap <= regrant_gap_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (N_REQ=4, DATA_W=8, MAX_BURST=4).
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic        fifo_full;
    logic [3:0]  grant;
    logic [3:0]  ack;
    logic        fifo_wr_en;
    logic [7:0]  fifo_din;
    logic [1:0]  owner;
    logic        busy;

    int tests;
    int fails;
    int wr_count;

    fifo_wr_arbiter #(
        .N_REQ     (4),
        .DATA_W    (8),
        .MAX_BURST (4),
        .IDX_W     (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_data   (req_data),
        .fifo_full  (fifo_full),
        .grant      (grant),
        .ack        (ack),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din),
        .owner      (owner),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: after the edge, drive inputs for the next edge, then let comb logic settle.
    task automatic cyc(input logic r, input logic [3:0] q, input logic f, input logic [31:0] d);
        @(posedge clk);
        #2;
        rst       = r;
        req       = q;
        fifo_full = f;
        req_data  = d;
        #1;
    endtask

    task automatic do_reset(input logic [3:0] q_next);
        cyc(1'b1, 4'b0000, 1'b0, 32'h0);
        cyc(1'b0, q_next, 1'b0, 32'h0);
    endtask

    logic [12:0] sole_pat;
    logic [7:0]  d0, d1;

    initial begin
        tests     = 0;
        fails     = 0;
        wr_count  = 0;
        rst       = 1'b1;
        req       = 4'b0110;
        fifo_full = 1'b0;
        req_data  = 32'h0;

        // Reset and first grant
        cyc(1'b1, 4'b0110, 1'b0, 32'h0);
        chk("rst_grant", grant, 4'b0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_wr_en", fifo_wr_en, 1'b0);
        cyc(1'b0, 4'b0110, 1'b0, 32'h0);
        chk("rst2_grant", grant, 4'b0000);
        chk("rst2_din", fifo_din, 8'h00);
        chk("rst2_owner", owner, 2'd0);
        cyc(1'b0, 4'b0110, 1'b0, 32'h0);
        chk("first_grant", grant, 4'b0010);
        chk("first_owner", owner, 2'd1);
        chk("first_busy", busy, 1'b1);

        // Burst limit: requester 0 then 1, four beats each
        do_reset(4'b0011);
        for (int k = 0; k < 9; k++) begin
            d0 = (k < 4) ? 8'(k) : 8'h04;
            d1 = (k < 4) ? 8'h10 : ((k < 8) ? 8'(8'h10 + k - 4) : 8'h14);
            cyc(1'b0, 4'b0011, 1'b0, {16'h0, d1, d0});
            if (k < 4) begin
                chk("burst_grant_r0", grant, 4'b0001);
                chk("burst_ack_r0", ack, 4'b0001);
                chk("burst_din_r0", fifo_din, 8'(k));
            end else if (k < 8) begin
                chk("burst_grant_r1", grant, 4'b0010);
                chk("burst_ack_r1", ack, 4'b0010);
                chk("burst_din_r1", fifo_din, 8'(8'h10 + k - 4));
            end else begin
                chk("burst_back_r0", grant, 4'b0001);
            end
        end

        // Full stall on requester 2
        do_reset(4'b0100);
        cyc(1'b0, 4'b0100, 1'b0, 32'h0020_0000);
        chk("stall_grant0", grant, 4'b0100);
        chk("stall_ack0", ack, 4'b0100);
        chk("stall_din0", fifo_din, 8'h20);
        for (int k = 1; k < 4; k++) begin
            cyc(1'b0, 4'b0100, 1'b1, 32'h0021_0000);
            chk("stall_ack_full", ack, 4'b0000);
            chk("stall_wr_full", fifo_wr_en, 1'b0);
            chk("stall_grant_full", grant, 4'b0100);
            chk("stall_beat_hold", dut.beat_cnt, 4'd1);
        end
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 4'b0100, 1'b0, {8'h0, 8'(8'h21 + k), 16'h0});
            chk("stall_ack_resume", ack, 4'b0100);
            chk("stall_din_resume", fifo_din, 8'(8'h21 + k));
        end
        cyc(1'b0, 4'b0000, 1'b0, 32'h0);
        chk("stall_done_wr", fifo_wr_en, 1'b0);
        cyc(1'b0, 4'b0000, 1'b0, 32'h0);
        chk("stall_idle_grant", grant, 4'b0000);
        chk("stall_idle_busy", busy, 1'b0);

        // Early release by requester 3, then rotation to requester 0
        do_reset(4'b1000);
        cyc(1'b0, 4'b1000, 1'b0, 32'h3000_0000);
        chk("early_grant", grant, 4'b1000);
        chk("early_ack0", ack, 4'b1000);
        cyc(1'b0, 4'b1000, 1'b0, 32'h3100_0000);
        chk("early_ack1", ack, 4'b1000);
        cyc(1'b0, 4'b0000, 1'b0, 32'h0);
        chk("early_drop_wr", fifo_wr_en, 1'b0);
        cyc(1'b0, 4'b1001, 1'b0, 32'h0);
        chk("early_busy", busy, 1'b0);
        chk("early_grant_idle", grant, 4'b0000);
        chk("early_owner_kept", owner, 2'd3);
        cyc(1'b0, 4'b1001, 1'b0, 32'h0);
        chk("rotate_grant", grant, 4'b0001);
        chk("rotate_owner", owner, 2'd0);

        // Sole requester: bursts 4, 4, 2 with one bubble between bursts
        sole_pat = 13'b0_11_0_1111_0_1111;
        do_reset(4'b0010);
        wr_count = 0;
        for (int c = 0; c < 13; c++) begin
            cyc(1'b0, (c < 12) ? 4'b0010 : 4'b0000, 1'b0, 32'h0000_1100);
            chk("sole_wr_en", fifo_wr_en, sole_pat[c]);
            if (fifo_wr_en) wr_count++;
        end
        cyc(1'b0, 4'b0000, 1'b0, 32'h0);
        chk("sole_count", 32'(wr_count), 32'd10);
        chk("sole_idle_busy", busy, 1'b0);

        // Reset in the middle of requester 0's burst
        do_reset(4'b0011);
        cyc(1'b0, 4'b0011, 1'b0, 32'h0);
        chk("midrst_ack0", ack, 4'b0001);
        cyc(1'b1, 4'b0011, 1'b0, 32'h0);
        chk("midrst_no_wr", fifo_wr_en, 1'b0);
        chk("midrst_no_ack", ack, 4'b0000);
        cyc(1'b0, 4'b0011, 1'b0, 32'h0);
        chk("midrst_grant_drop", grant, 4'b0000);
        chk("midrst_busy_drop", busy, 1'b0);
        cyc(1'b0, 4'b0011, 1'b0, 32'h0);
        chk("midrst_regrant", grant, 4'b0001);
        chk("midrst_owner", owner, 2'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
